// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller behind a UART receiver: SYNC, ADDR, LEN, payload, CSUM.
// Define UART_FRAME_STATS_EN to add saturating good/error frame counters.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 4000,
  parameter int         TIMEOUT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  data_out,
  output logic [7:0]  data_index,
  output logic        data_valid,
  output logic [7:0]  frame_addr,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    GET_DATA,
    GET_CSUM,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [7:0]           addr_tmp;
  logic [7:0]           len;
  logic [7:0]           idx;
  logic [7:0]           sum;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_next;
  logic [7:0]           buf_mem [DEPTH];

  logic       in_frame;
  logic       tmo_hit;
  logic       accept;
  logic       err_fire;
  logic [1:0] err_code_next;
  logic       done_fire;
  logic       emit;
  logic       ld_addr;
  logic       ld_len;
  logic       ld_data;
  logic       csum_ok;

  // Line error outranks timeout, which outranks a byte arriving on the same edge.
  always_comb begin
    state_next    = state;
    err_fire      = 1'b0;
    err_code_next = err_code;
    done_fire     = 1'b0;
    emit          = 1'b0;
    ld_addr       = 1'b0;
    ld_len        = 1'b0;
    ld_data       = 1'b0;
    csum_ok       = 1'b0;
    tmo_next      = '0;

    in_frame = (state == GET_ADDR) || (state == GET_LEN) ||
               (state == GET_DATA) || (state == GET_CSUM);
    tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    accept   = in_frame && rx_valid && !rx_error;

    case (state)
      IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_next = GET_ADDR;
        end
      end
      DRAIN: begin
        if (idx == len) begin
          done_fire  = 1'b1;
          state_next = IDLE;
        end else begin
          emit = 1'b1;
        end
      end
      default: begin
        if (rx_error) begin
          err_fire      = 1'b1;
          err_code_next = 2'd3;
          state_next    = IDLE;
        end else if (tmo_hit) begin
          err_fire      = 1'b1;
          err_code_next = 2'd2;
          state_next    = IDLE;
        end else if (accept) begin
          case (state)
            GET_ADDR: begin
              ld_addr    = 1'b1;
              state_next = GET_LEN;
            end
            GET_LEN: begin
              if (rx_byte > MAX_LEN_B) begin
                err_fire      = 1'b1;
                err_code_next = 2'd1;
                state_next    = IDLE;
              end else begin
                ld_len     = 1'b1;
                state_next = (rx_byte == 8'd0) ? GET_CSUM : GET_DATA;
              end
            end
            GET_DATA: begin
              ld_data = 1'b1;
              if ((idx + 8'd1) == len) begin
                state_next = GET_CSUM;
              end
            end
            GET_CSUM: begin
              if (rx_byte == sum) begin
                csum_ok    = 1'b1;
                state_next = DRAIN;
              end else begin
                err_fire      = 1'b1;
                err_code_next = 2'd0;
                state_next    = IDLE;
              end
            end
            default: begin
            end
          endcase
        end
      end
    endcase

    if (in_frame && !accept && (state_next != IDLE) && (state_next != DRAIN)) begin
      tmo_next = tmo_cnt + 1'b1;
    end
  end

  // idx is the write pointer while collecting and the read pointer while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_tmp   <= '0;
      len        <= '0;
      idx        <= '0;
      sum        <= '0;
      tmo_cnt    <= '0;
      data_out   <= '0;
      data_index <= '0;
      data_valid <= 1'b0;
      frame_addr <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != IDLE);
      tmo_cnt    <= tmo_next;
      frame_err  <= err_fire;
      frame_done <= done_fire;
      data_valid <= emit;
      if (err_fire) begin
        err_code <= err_code_next;
      end
      if (ld_addr) begin
        addr_tmp <= rx_byte;
        sum      <= rx_byte;
      end
      if (ld_len) begin
        len <= rx_byte;
        sum <= sum + rx_byte;
        idx <= '0;
      end
      if (ld_data) begin
        sum <= sum + rx_byte;
        idx <= idx + 8'd1;
      end
      if (csum_ok) begin
        frame_addr <= addr_tmp;
        idx        <= '0;
      end
      if (emit) begin
        data_out   <= buf_mem[idx[IDX_W-1:0]];
        data_index <= idx;
        idx        <= idx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_data) begin
      buf_mem[idx[IDX_W-1:0]] <= rx_byte;
    end
  end

`ifdef UART_FRAME_STATS_EN
  // Counters follow the registered pulses, so they update one cycle after each pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (frame_done && (good_cnt != 16'hFFFF)) begin
        good_cnt <= good_cnt + 16'd1;
      end
      if (frame_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics counters are compiled out; the stats ports do not exist.
`endif

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller placed after the UART receiver. It takes the receiver's byte strobes and sequences them through a fixed packet format: SYNC, ADDR, LEN, LEN payload bytes, CSUM. The payload is buffered internally and released downstream only after the checksum passes. Bad frames are rejected with an error code, and an inter-byte timeout recovers the controller when a frame stalls.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 16, maximum payload bytes (1..255); sets the buffer depth
TIMEOUT_CLKS, 4000, idle clocks allowed between bytes inside a frame before abort
TIMEOUT_W, 16, timeout counter width; must hold TIMEOUT_CLKS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
rx_byte  in  8  byte from the UART receiver; valid only while rx_valid=1
rx_valid  in  1  1-cycle pulse: a byte was received with a good stop bit
rx_error  in  1  1-cycle pulse: framing error on the line
data_out  out  8  payload byte
data_index  out  8  payload byte position, starting at 0
data_valid  out  1  data_out and data_index are valid this cycle
frame_addr  out  8  ADDR field of the last accepted frame
frame_done  out  1  1-cycle pulse: frame completed and checksum good
frame_err  out  1  1-cycle pulse: frame aborted
err_code  out  2  abort reason, valid with frame_err: 0 checksum, 1 length, 2 timeout, 3 line error
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. While rst=1, every output, the state, the counters and the running sum are 0, and the state is IDLE. Buffer contents are don't-care. Reset asserted mid-frame drops the frame with no error pulse.
- A byte is accepted on the edge where rx_valid=1. The state changes at that same edge.
- States and transitions:
  - IDLE: if rx_byte==SYNC_BYTE, go to GET_ADDR. Any other byte is dropped silently. rx_error is ignored in IDLE.
  - GET_ADDR: latch the byte into addr_tmp; set sum=byte; go to GET_LEN.
  - GET_LEN:
    - If byte>MAX_LEN: pulse frame_err with err_code=1; go to IDLE.
    - If byte==0: go to GET_CSUM.
    - Otherwise: store len, set sum+=byte, set idx=0, go to GET_DATA.
  - GET_DATA: write buf[idx]=byte; sum+=byte; idx++. Go to GET_CSUM when idx reaches len.
  - GET_CSUM:
    - If byte==sum[7:0]: copy addr_tmp to frame_addr and go to DRAIN.
    - Otherwise: pulse frame_err with err_code=0; go to IDLE.
  - DRAIN: one buffered byte per cycle. data_valid=1 with data_index=0..len-1 on consecutive cycles. On the cycle after the last byte, pulse frame_done and go to IDLE. With len=0, frame_done pulses on the cycle after the CSUM edge and data_valid never asserts.
- Output timing: the first data_valid is the cycle after the CSUM accept edge. frame_done is len+1 cycles after that edge.
- Checksum: 8-bit sum modulo 256 of ADDR, LEN and all payload bytes. SYNC and CSUM are excluded.
- Timeout:
  - Counter reloads to 0 on every accepted byte and on entry to GET_ADDR.
  - It counts in GET_ADDR, GET_LEN, GET_DATA and GET_CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no rx_valid: pulse frame_err with err_code=2; go to IDLE.
  - It is held at 0 in IDLE and DRAIN.
- Line error: rx_error in GET_ADDR through GET_CSUM pulses frame_err with err_code=3 and returns to IDLE.
- Simultaneous events, in priority order:
  - rst
  - rx_error (the byte accompanying it is discarded)
  - timeout
  - rx_valid
- Bytes arriving during DRAIN are discarded with no error. This includes a SYNC_BYTE: it does not start a frame.
- Between frames: data_out and data_index hold their last values. frame_addr holds until the next good frame. frame_err and frame_done are never high in the same cycle.

Optional Feature:
Macro UART_FRAME_STATS_EN.
- When defined, adds two output ports:
  - good_cnt (16 bits): +1 per frame_done pulse.
  - err_cnt (16 bits): +1 per frame_err pulse.
- Both counters saturate at 16'hFFFF and clear to 0 on rst.
- When not defined, these ports and their logic are absent. All other behaviour is identical in both builds.

Test Plan:
- Good frame: A5,07,02,11,22,3C -> data_valid on 2 consecutive cycles with (0,11) then (1,22); frame_addr=07; frame_done 3 cycles after the CSUM accept; frame_err never high.
- Bad checksum: A5,07,02,11,22,3D -> frame_err with err_code=0; no data_valid; frame_addr unchanged. Then a good frame sent immediately after is accepted.
- Length limit: A5,01,11 with MAX_LEN=16 -> frame_err with err_code=1 right after the LEN byte. Next, a zero-length frame A5,01,00,01 -> frame_done 1 cycle after CSUM, no data_valid.
- Timeout: A5,07, then silence -> frame_err with err_code=2 exactly TIMEOUT_CLKS cycles after the ADDR accept; busy drops to 0.
- Line error and priority: rx_error and rx_valid pulsed in the same cycle during GET_DATA -> err_code=3 and the byte is discarded. rx_error in IDLE -> no response. Garbage bytes 00,FF in IDLE -> ignored.
- Reset mid-frame: assert rst during GET_DATA -> all outputs 0 asynchronously; after release, a good frame is accepted normally. With UART_FRAME_STATS_EN defined: good_cnt and err_cnt match the number of done and error pulses.
